// File: rtl/io_read_port_select_hs.sv
// Full-address decoder for a contiguous block of I/O read ports with a per-port
// ready/consume handshake, a registered output pipeline and a saturating stall counter.
module io_read_port_select_hs #(
   parameter int WORD_WIDTH           = 36,
   parameter int ADDR_WIDTH           = 10,
   parameter int READ_PORT_COUNT      = 4,
   parameter int READ_PORT_BASE_ADDR  = 1020,
   parameter int READ_PORT_ADDR_WIDTH = 2,
   parameter int PIPE_DEPTH           = 2,
   parameter int STALL_COUNT_WIDTH    = 16
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [ADDR_WIDTH-1:0]                 read_addr,
   input  logic                                  read_valid,
   input  logic [READ_PORT_COUNT*WORD_WIDTH-1:0] read_data_in,
   input  logic [READ_PORT_COUNT-1:0]            read_rdy_in,
   output logic [READ_PORT_COUNT-1:0]            read_en_out,
   output logic                                  io_ready,
   output logic                                  io_read_hit,
   output logic [WORD_WIDTH-1:0]                 read_data_selected,
   output logic                                  read_data_valid,
   output logic [STALL_COUNT_WIDTH-1:0]          stall_count
);

   localparam logic [ADDR_WIDTH:0] BASE_EXT  = (ADDR_WIDTH+1)'(READ_PORT_BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] COUNT_EXT = (ADDR_WIDTH+1)'(READ_PORT_COUNT);

   logic [ADDR_WIDTH:0]           offset;
   logic [READ_PORT_ADDR_WIDTH-1:0] idx;
   logic                          hit;
   logic                          rdy_sel;
   logic [WORD_WIDTH-1:0]         word_sel;
   logic                          accept;

   logic [WORD_WIDTH-1:0]         data_p [PIPE_DEPTH];
   logic                          vld_p  [PIPE_DEPTH];

   function automatic logic [STALL_COUNT_WIDTH-1:0] sat_inc(input logic [STALL_COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // One extra bit makes addresses below the base wrap to huge offsets, so a single
   // full-width compare rejects both sides of the window and any low-bit alias.
   assign offset = {1'b0, read_addr} - BASE_EXT;
   assign idx    = offset[READ_PORT_ADDR_WIDTH-1:0];
   assign hit    = !reset && read_valid && (offset < COUNT_EXT);

   always_comb begin
      rdy_sel     = 1'b0;
      word_sel    = '0;
      read_en_out = '0;
      for (int i = 0; i < READ_PORT_COUNT; i++) begin
         if (idx == READ_PORT_ADDR_WIDTH'(i)) begin
            rdy_sel        = read_rdy_in[i];
            word_sel       = read_data_in[i*WORD_WIDTH +: WORD_WIDTH];
            read_en_out[i] = hit && read_rdy_in[i];
         end
      end
   end

   assign accept      = hit && rdy_sel;
   assign io_ready    = !hit || rdy_sel;
   assign io_read_hit = hit;

   // Stage 1 captures the strobed word (zero otherwise, for OR-merging); later stages shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            data_p[k] <= '0;
            vld_p[k]  <= 1'b0;
         end
         stall_count <= '0;
      end else begin
         data_p[0] <= accept ? word_sel : '0;
         vld_p[0]  <= accept;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            data_p[k] <= data_p[k-1];
            vld_p[k]  <= vld_p[k-1];
         end
         if (hit && !rdy_sel)
            stall_count <= sat_inc(stall_count);
      end
   end

   assign read_data_selected = data_p[PIPE_DEPTH-1];
   assign read_data_valid    = vld_p[PIPE_DEPTH-1];

endmodule

// File: tb/tb_io_read_port_select_hs.sv
// Directed bench for io_read_port_select_hs: per-cycle vector table plus stall,
// saturation and mid-stream reset sequences.
module tb_io_read_port_select_hs;

   localparam int W   = 36;
   localparam int AW  = 10;
   localparam int N   = 4;
   localparam int SCW = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic [AW-1:0]   read_addr;
   logic            read_valid;
   logic [N*W-1:0]  read_data_in;
   logic [N-1:0]    read_rdy_in;
   logic [N-1:0]    read_en_out;
   logic            io_ready;
   logic            io_read_hit;
   logic [W-1:0]    read_data_selected;
   logic            read_data_valid;
   logic [SCW-1:0]  stall_count;

   int tests = 0;
   int fails = 0;

   io_read_port_select_hs #(
      .WORD_WIDTH(W), .ADDR_WIDTH(AW), .READ_PORT_COUNT(N), .READ_PORT_BASE_ADDR(1020),
      .READ_PORT_ADDR_WIDTH(2), .PIPE_DEPTH(2), .STALL_COUNT_WIDTH(SCW)
   ) dut (
      .clock(clock), .reset(reset), .read_addr(read_addr), .read_valid(read_valid),
      .read_data_in(read_data_in), .read_rdy_in(read_rdy_in), .read_en_out(read_en_out),
      .io_ready(io_ready), .io_read_hit(io_read_hit), .read_data_selected(read_data_selected),
      .read_data_valid(read_data_valid), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic           rst;
      logic [AW-1:0]  addr;
      logic           vld;
      logic [N-1:0]   rdy;
      logic [N-1:0]   en;
      logic           ior;
      logic           hit;
      logic [W-1:0]   data;
      logic           dv;
      logic [SCW-1:0] stall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, int addr, logic vld, logic [N-1:0] rdy, logic [N-1:0] en,
                               logic ior, logic hit, logic [W-1:0] data, logic dv, int stall);
      vec_t v;
      v.rst = rst; v.addr = AW'(addr); v.vld = vld; v.rdy = rdy; v.en = en;
      v.ior = ior; v.hit = hit; v.data = data; v.dv = dv; v.stall = SCW'(stall);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input int addr, input logic vld, input logic [N-1:0] rdy);
      reset = rst; read_addr = AW'(addr); read_valid = vld; read_rdy_in = rdy;
   endtask

   // Moves from the mid-cycle check point to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic set_port(input int p, input logic [W-1:0] d);
      read_data_in[p*W +: W] = d;
   endtask

   initial begin
      set_port(0, 36'h111); set_port(1, 36'h222); set_port(2, 36'hABC); set_port(3, 36'h444);
      drive(1'b1, 1022, 1'b1, 4'b1111);
      repeat (2) @(posedge clock);
      #1;
      @(negedge clock);
      chk("reset_en",    64'(read_en_out), 64'h0);
      chk("reset_ior",   64'(io_ready), 64'h1);
      chk("reset_hit",   64'(io_read_hit), 64'h0);
      chk("reset_data",  64'(read_data_selected), 64'h0);
      chk("reset_dv",    64'(read_data_valid), 64'h0);
      chk("reset_stall", 64'(stall_count), 64'h0);
      next_cycle();

      //               rst addr  vld rdy      en       ior  hit  data      dv  stall
      vecs.push_back(mk(0, 1022, 1, 4'b1111, 4'b0100, 1, 1, 36'h0,   0, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'hABC, 1, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 508,  1, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 1019, 1, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 1020, 1, 4'b1111, 4'b0001, 1, 1, 36'h0,   0, 0));
      vecs.push_back(mk(0, 1023, 1, 4'b1111, 4'b1000, 1, 1, 36'h0,   0, 0));
      vecs.push_back(mk(0, 1020, 1, 4'b1111, 4'b0001, 1, 1, 36'h111, 1, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h444, 1, 0));
      vecs.push_back(mk(0, 1022, 0, 4'b1111, 4'b0000, 1, 0, 36'h111, 1, 0));
      vecs.push_back(mk(1, 1021, 1, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 1021, 1, 4'b1111, 4'b0010, 1, 1, 36'h0,   0, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h0,   0, 0));
      vecs.push_back(mk(0, 0,    0, 4'b1111, 4'b0000, 1, 0, 36'h222, 1, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, int'(vecs[i].addr), vecs[i].vld, vecs[i].rdy);
         @(negedge clock);
         chk($sformatf("v%0d_en", i),    64'(read_en_out), 64'(vecs[i].en));
         chk($sformatf("v%0d_ior", i),   64'(io_ready), 64'(vecs[i].ior));
         chk($sformatf("v%0d_hit", i),   64'(io_read_hit), 64'(vecs[i].hit));
         chk($sformatf("v%0d_data", i),  64'(read_data_selected), 64'(vecs[i].data));
         chk($sformatf("v%0d_dv", i),    64'(read_data_valid), 64'(vecs[i].dv));
         chk($sformatf("v%0d_stall", i), 64'(stall_count), 64'(vecs[i].stall));
         next_cycle();
      end

      // Port 1 not ready for 5 cycles, then ready on the 6th.
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1021, 1'b1, 4'b0000);
         @(negedge clock);
         chk("stall_en",    64'(read_en_out), 64'h0);
         chk("stall_ior",   64'(io_ready), 64'h0);
         chk("stall_hit",   64'(io_read_hit), 64'h1);
         chk("stall_cnt",   64'(stall_count), 64'(k));
         next_cycle();
      end
      drive(1'b0, 1021, 1'b1, 4'b0010);
      @(negedge clock);
      chk("release_cnt", 64'(stall_count), 64'h5);
      chk("release_en",  64'(read_en_out), 64'h2);
      chk("release_ior", 64'(io_ready), 64'h1);
      next_cycle();
      drive(1'b0, 0, 1'b0, 4'b1111);
      set_port(1, 36'hFFF);
      @(negedge clock);
      chk("release_p1_data", 64'(read_data_selected), 64'h0);
      chk("release_p1_dv",   64'(read_data_valid), 64'h0);
      next_cycle();
      @(negedge clock);
      chk("release_p2_data", 64'(read_data_selected), 64'h222);
      chk("release_p2_dv",   64'(read_data_valid), 64'h1);
      chk("release_p2_cnt",  64'(stall_count), 64'h5);
      next_cycle();
      @(negedge clock);
      chk("release_p3_dv",   64'(read_data_valid), 64'h0);
      next_cycle();
      set_port(1, 36'h222);

      // Saturation: 20 more stalled cycles on port 3 from a count of 5.
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1023, 1'b1, 4'b0111);
         @(negedge clock);
         chk("sat_ior", 64'(io_ready), 64'h0);
         chk("sat_cnt", 64'(stall_count), 64'((5 + k > 15) ? 15 : 5 + k));
         next_cycle();
      end
      drive(1'b0, 0, 1'b0, 4'b1111);
      @(negedge clock);
      chk("sat_hold", 64'(stall_count), 64'hF);
      next_cycle();

      // Read in flight when a one-cycle reset arrives with a hit on a ready port.
      drive(1'b0, 1022, 1'b1, 4'b1111);
      @(negedge clock);
      chk("pre_rst_en", 64'(read_en_out), 64'h4);
      next_cycle();
      drive(1'b1, 1022, 1'b1, 4'b1111);
      @(negedge clock);
      chk("rst_en",  64'(read_en_out), 64'h0);
      chk("rst_ior", 64'(io_ready), 64'h1);
      chk("rst_hit", 64'(io_read_hit), 64'h0);
      next_cycle();
      drive(1'b0, 0, 1'b0, 4'b1111);
      @(negedge clock);
      chk("post_rst_cnt",  64'(stall_count), 64'h0);
      chk("post_rst_data", 64'(read_data_selected), 64'h0);
      chk("post_rst_dv",   64'(read_data_valid), 64'h0);
      next_cycle();
      @(negedge clock);
      chk("post_rst2_dv",  64'(read_data_valid), 64'h0);
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
